// File: rtl/imm_pkg.sv
//------------------------------------------------------------------------------
// imm_pkg : immediate-format select codes and skid-buffer occupancy states
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_RSVD  = 3'b111;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
//------------------------------------------------------------------------------
// imm_decode : combinational RISC-V immediate extraction for all formats
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  // Signed formats are first assembled at 32 bits, then widened by sign.
  logic [31:0]     w_sext32;
  logic [XLEN-1:0] w_zval;
  logic            w_zext;

  always_comb begin
    w_sext32 = '0;
    w_zval   = '0;
    w_zext   = 1'b0;
    err      = 1'b0;
    case (imm_src)
      IMM_I:     w_sext32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     w_sext32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     w_sext32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
      IMM_J:     w_sext32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
      IMM_U:     w_sext32 = {instr[31:12], 12'b0};
      IMM_SHAMT: begin
        w_zext = 1'b1;
        w_zval = XLEN'(instr[20 +: SHAMT_W]);
      end
      IMM_ZIMM: begin
        w_zext = 1'b1;
        w_zval = XLEN'(instr[19:15]);
      end
      default: begin
        w_zext = 1'b1;
        err    = 1'b1;
      end
    endcase
    imm = w_zext ? w_zval : XLEN'($signed(w_sext32));
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
//------------------------------------------------------------------------------
// imm_gen_pipe : registered immediate generator behind a 2-entry skid buffer
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_fmt_err
);

  occ_state_e      r_state;
  occ_state_e      w_state_nxt;
  logic [XLEN-1:0] r_out_imm;
  logic [XLEN-1:0] r_skid_imm;
  logic            r_out_err;
  logic            r_skid_err;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_dec_err;
  logic            w_accept;
  logic            w_consume;
  logic            w_load_out_dec;
  logic            w_load_out_skid;
  logic            w_load_skid;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (w_dec_imm),
    .err     (w_dec_err)
  );

  // in_ready depends on state only, keeping out_ready off any input path.
  assign in_ready    = (r_state != OCC_TWO) && !reset;
  assign out_valid   = (r_state != OCC_EMPTY);
  assign w_accept    = in_valid && in_ready;
  assign w_consume   = out_valid && out_ready;
  assign imm_ext     = r_out_imm;
  assign imm_fmt_err = r_out_err;

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_dec  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = OCC_ONE;
          w_load_out_dec = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_accept && w_consume) begin
          w_load_out_dec = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = OCC_TWO;
          w_load_skid = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (w_consume) begin
          w_state_nxt     = OCC_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_imm  <= '0;
      r_out_err  <= 1'b0;
      r_skid_imm <= '0;
      r_skid_err <= 1'b0;
    end else begin
      if (w_load_out_dec) begin
        r_out_imm <= w_dec_imm;
        r_out_err <= w_dec_err;
      end else if (w_load_out_skid) begin
        r_out_imm <= r_skid_imm;
        r_out_err <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_dec_imm;
        r_skid_err <= w_dec_err;
      end
    end
  end

endmodule

`default_nettype wire
